// File: rtl/riscv_pipelined_cpu.sv
// 5-stage in-order RV32I core (IF/ID/EX/MEM/WB). Internal instruction ROM and
// data RAM. Operands are forwarded into EX, a load followed by a dependent
// instruction costs one stall cycle, and branches/jumps resolve in EX.

// Instruction ROM, word indexed. Contents are preloaded from outside (e.g. by
// the bench through the hierarchy) before reset is released; the core never writes it.
module riscv_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] i_idx,
  output logic [31:0]   o_instr
);
  logic [31:0] rom_memory [DEPTH] = '{default: 32'h0};

  assign o_instr = rom_memory[i_idx];
endmodule

// Fetch stage: the PC register lives in the top level, so this stage only
// indexes the ROM. The index is a PC slice, so fetch wraps modulo ROM size.
module riscv_if_stage #(
  parameter int IMEM_DEPTH = 1024,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic [AW-1:0] i_idx,
  output logic [31:0]   o_instr
);
  riscv_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) imem_inst (
    .i_idx   (i_idx),
    .o_instr (o_instr)
  );
endmodule

// 32 x 32 register file. It is write-first, so a WB write in the same cycle
// bypasses to the ID read ports. x0 always reads as zero.
module riscv_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wd
);
  logic [31:0] register_memory [0:31];

  // Clear all registers on reset; otherwise write one register per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) register_memory[i] <= '0;
    end else if (i_we && i_rd != 5'd0) begin
      register_memory[i_rd] <= i_wd;
    end
  end

  // Read ports with same-cycle write bypass.
  always_comb begin
    o_rs1 = (i_we && i_rd == i_rs1) ? i_wd : register_memory[i_rs1];
    o_rs2 = (i_we && i_rd == i_rs2) ? i_wd : register_memory[i_rs2];
    if (i_rs1 == 5'd0) o_rs1 = '0;
    if (i_rs2 == 5'd0) o_rs2 = '0;
  end
endmodule

module riscv_pipelined_cpu #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  // asel: 0 = rs1, 1 = PC, 2 = zero. aop = {sub/sra, funct3}.
  typedef struct packed {
    logic       wr;
    logic       pc4;
    logic       ld;
    logic       st;
    logic       br;
    logic       jal;
    logic       jalr;
    logic [1:0] asel;
    logic       bimm;
    logic [3:0] aop;
  } ctrl_t;

  // Valid bit of each pipeline register: [1] IF/ID, [2] ID/EX,
  // [3] EX/MEM, [4] MEM/WB. A cleared bit marks a bubble.
  logic [4:1]  r_vld_pipe;
  logic [31:0] if_pc;
  logic [31:0] w_if_instr;
  logic [31:0] r_ifid_pc, r_ifid_instr;
  ctrl_t       w_dc;
  logic [31:0] w_imm, w_rs1v, w_rs2v;
  logic        w_use1, w_use2;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  ctrl_t       r_idex_ctrl;
  logic [31:0] r_idex_pc, r_idex_imm, r_idex_rs1v, r_idex_rs2v;
  logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
  logic [2:0]  r_idex_f3;
  logic [31:0] w_fa, w_fb, w_opa, w_opb, w_alu, w_ex_res, w_tgt;
  logic        w_cond, w_take, w_stall;
  logic [31:0] r_exmem_res, r_exmem_sd;
  logic [4:0]  r_exmem_rd;
  logic        r_exmem_wr, r_exmem_ld, r_exmem_st;
  logic [31:0] r_memwb_res, r_memwb_rdata;
  logic [4:0]  r_memwb_rd;
  logic        r_memwb_wr, r_memwb_ld;
  logic        w_wb_we;
  logic [31:0] w_wb_data;
  logic [31:0] r_dmem [DMEM_DEPTH];

  riscv_if_stage #(.IMEM_DEPTH(IMEM_DEPTH), .AW(IAW)) if_stage_inst (
    .i_idx   (if_pc[IAW+1:2]),
    .o_instr (w_if_instr)
  );

  assign w_opc = r_ifid_instr[6:0];
  assign w_rd  = r_ifid_instr[11:7];
  assign w_f3  = r_ifid_instr[14:12];
  assign w_rs1 = r_ifid_instr[19:15];
  assign w_rs2 = r_ifid_instr[24:20];
  assign w_f7  = r_ifid_instr[31:25];

  riscv_reg_file reg_file_inst (
    .clk   (clk),
    .rst   (rst),
    .i_rs1 (w_rs1),
    .i_rs2 (w_rs2),
    .o_rs1 (w_rs1v),
    .o_rs2 (w_rs2v),
    .i_we  (w_wb_we),
    .i_rd  (r_memwb_rd),
    .i_wd  (w_wb_data)
  );

  // Decode: control and immediate. Unsupported encodings stay all-zero (NOP).
  always_comb begin
    w_dc   = '0;
    w_imm  = '0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (w_opc)
      7'h37: begin // LUI
        w_dc.wr = 1'b1; w_dc.asel = 2'd2; w_dc.bimm = 1'b1;
        w_imm = {r_ifid_instr[31:12], 12'h0};
      end
      7'h17: begin // AUIPC
        w_dc.wr = 1'b1; w_dc.asel = 2'd1; w_dc.bimm = 1'b1;
        w_imm = {r_ifid_instr[31:12], 12'h0};
      end
      7'h6f: begin // JAL
        w_dc.wr = 1'b1; w_dc.pc4 = 1'b1; w_dc.jal = 1'b1;
        w_imm = {{11{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[19:12],
                 r_ifid_instr[20], r_ifid_instr[30:21], 1'b0};
      end
      7'h67: if (w_f3 == 3'b000) begin // JALR
        w_dc.wr = 1'b1; w_dc.pc4 = 1'b1; w_dc.jalr = 1'b1; w_use1 = 1'b1;
        w_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
      end
      7'h63: if (w_f3[2:1] != 2'b01) begin // branches
        w_dc.br = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
        w_imm = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                 r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
      end
      7'h03: if (w_f3 == 3'b010) begin // LW
        w_dc.wr = 1'b1; w_dc.ld = 1'b1; w_dc.bimm = 1'b1; w_use1 = 1'b1;
        w_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
      end
      7'h23: if (w_f3 == 3'b010) begin // SW
        w_dc.st = 1'b1; w_dc.bimm = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
        w_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
      end
      7'h13: if (w_f3 == 3'b001 ? w_f7 == 7'h00 :
                 w_f3 == 3'b101 ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1) begin
        w_dc.wr = 1'b1; w_dc.bimm = 1'b1; w_use1 = 1'b1;
        w_dc.aop = {w_f3 == 3'b101 && r_ifid_instr[30], w_f3};
        w_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
      end
      7'h33: if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
        w_dc.wr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
        w_dc.aop = {r_ifid_instr[30], w_f3};
      end
      default: ;
    endcase
  end

  // Load-use hazard: a load in EX whose rd is read by the instruction in ID.
  assign w_stall = r_vld_pipe[2] && r_idex_ctrl.ld && r_idex_rd != 5'd0 && r_vld_pipe[1] &&
                   ((w_use1 && w_rs1 == r_idex_rd) || (w_use2 && w_rs2 == r_idex_rd));

  assign w_wb_we   = r_vld_pipe[4] && r_memwb_wr;
  assign w_wb_data = r_memwb_ld ? r_memwb_rdata : r_memwb_res;

  // EX operand forwarding: EX/MEM first, then MEM/WB, else the ID/EX copy.
  // The *_wr flags are already cleared for rd = x0.
  always_comb begin
    w_fa = r_idex_rs1v;
    w_fb = r_idex_rs2v;
    if (r_vld_pipe[3] && r_exmem_wr && !r_exmem_ld && r_exmem_rd == r_idex_rs1) w_fa = r_exmem_res;
    else if (w_wb_we && r_memwb_rd == r_idex_rs1)                               w_fa = w_wb_data;
    if (r_vld_pipe[3] && r_exmem_wr && !r_exmem_ld && r_exmem_rd == r_idex_rs2) w_fb = r_exmem_res;
    else if (w_wb_we && r_memwb_rd == r_idex_rs2)                               w_fb = w_wb_data;
  end

  // ALU, branch compare, and redirect target.
  always_comb begin
    w_opa = (r_idex_ctrl.asel == 2'd1) ? r_idex_pc :
            (r_idex_ctrl.asel == 2'd2) ? 32'h0 : w_fa;
    w_opb = r_idex_ctrl.bimm ? r_idex_imm : w_fb;
    case (r_idex_ctrl.aop[2:0])
      3'b000:  w_alu = r_idex_ctrl.aop[3] ? w_opa - w_opb : w_opa + w_opb;
      3'b001:  w_alu = w_opa << w_opb[4:0];
      3'b010:  w_alu = {31'h0, $signed(w_opa) < $signed(w_opb)};
      3'b011:  w_alu = {31'h0, w_opa < w_opb};
      3'b100:  w_alu = w_opa ^ w_opb;
      3'b101:  w_alu = r_idex_ctrl.aop[3] ? 32'($signed(w_opa) >>> w_opb[4:0]) : w_opa >> w_opb[4:0];
      3'b110:  w_alu = w_opa | w_opb;
      default: w_alu = w_opa & w_opb;
    endcase
    case (r_idex_f3)
      3'b000:  w_cond = (w_fa == w_fb);
      3'b001:  w_cond = (w_fa != w_fb);
      3'b100:  w_cond = ($signed(w_fa) <  $signed(w_fb));
      3'b101:  w_cond = ($signed(w_fa) >= $signed(w_fb));
      3'b110:  w_cond = (w_fa <  w_fb);
      3'b111:  w_cond = (w_fa >= w_fb);
      default: w_cond = 1'b0;
    endcase
    w_take   = r_vld_pipe[2] && (r_idex_ctrl.jal || r_idex_ctrl.jalr || (r_idex_ctrl.br && w_cond));
    w_tgt    = r_idex_ctrl.jalr ? ((w_fa + r_idex_imm) & ~32'h1) : r_idex_pc + r_idex_imm;
    w_ex_res = r_idex_ctrl.pc4 ? r_idex_pc + 32'd4 : w_alu;
  end

  // PC and valid bits: a redirect flushes IF/ID and ID/EX and overrides a
  // stall; a stall holds PC and IF/ID and drops a bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc      <= RESET_PC;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[3] <= r_vld_pipe[2];
      r_vld_pipe[4] <= r_vld_pipe[3];
      if (w_take) begin
        if_pc           <= w_tgt;
        r_vld_pipe[2:1] <= 2'b00;
      end else if (w_stall) begin
        r_vld_pipe[2] <= 1'b0;
      end else begin
        if_pc         <= if_pc + 32'd4;
        r_vld_pipe[1] <= 1'b1;
        r_vld_pipe[2] <= r_vld_pipe[1];
      end
    end
  end

  // Pipeline datapath registers; their meaning is qualified by r_vld_pipe.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_ifid_pc    <= if_pc;
      r_ifid_instr <= w_if_instr;
    end
    r_idex_ctrl   <= w_dc;
    r_idex_pc     <= r_ifid_pc;
    r_idex_imm    <= w_imm;
    r_idex_rs1v   <= w_rs1v;
    r_idex_rs2v   <= w_rs2v;
    r_idex_rs1    <= w_rs1;
    r_idex_rs2    <= w_rs2;
    r_idex_rd     <= w_rd;
    r_idex_f3     <= w_f3;
    r_exmem_res   <= w_ex_res;
    r_exmem_sd    <= w_fb;
    r_exmem_rd    <= r_idex_rd;
    r_exmem_wr    <= r_idex_ctrl.wr && r_idex_rd != 5'd0;
    r_exmem_ld    <= r_idex_ctrl.ld;
    r_exmem_st    <= r_idex_ctrl.st;
    r_memwb_res   <= r_exmem_res;
    r_memwb_rdata <= r_dmem[r_exmem_res[DAW+1:2]];
    r_memwb_rd    <= r_exmem_rd;
    r_memwb_wr    <= r_exmem_wr;
    r_memwb_ld    <= r_exmem_ld;
  end

  // Data RAM store in MEM; a store caught by reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && r_vld_pipe[3] && r_exmem_st) r_dmem[r_exmem_res[DAW+1:2]] <= r_exmem_sd;
  end
endmodule

// File: tb/tb_riscv_pipelined_cpu.sv
// Self-checking bench for riscv_pipelined_cpu: small hand-assembled programs,
// expected register values queued at load time and compared after the run.
module tb_riscv_pipelined_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    int          r;
    logic [31:0] v;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] prog[$];

  riscv_pipelined_cpu #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Encoders (arguments are plain ints, sliced into fields here).
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int f3, input int rs1, input int rs2);
    logic [31:0] m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    logic [31:0] m = imm20;
    return {m[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] rf(input int r);
    return dut.reg_file_inst.register_memory[r];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset, load the ROM (zero words decode as NOP), release reset.
  task automatic load_prog();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) dut.if_stage_inst.imem_inst.rom_memory[i] = 32'h0;
    foreach (prog[i]) dut.if_stage_inst.imem_inst.rom_memory[i] = prog[i];
    check("rst_pc", dut.if_pc, 32'h0);
    check("rst_x1", rf(1), 32'h0);
    rst = 1'b0;
  endtask

  task automatic exp_reg(input string tag, input int r, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.r = r; e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, rf(e.r), e.v);
    end
  endtask

  task automatic load_fib();
    prog = '{addi(1, 0, 10), addi(2, 0, 0), addi(3, 0, 1), addi(4, 0, 1),
             enc_r(0, 3, 2, 0, 5),     // 16: add  x5,x2,x3
             addi(2, 3, 0),            // 20: x2 = x3
             addi(3, 5, 0),            // 24: x3 = x5
             enc_r(32, 4, 1, 0, 1),    // 28: sub  x1,x1,x4
             enc_b(-16, 1, 1, 0)};     // 32: bne  x1,x0,16
    load_prog();
  endtask

  initial begin
    // LUI, first-retire latency.
    prog = '{enc_u(32'h12345, 1, 7'h37)};
    load_prog();
    cyc(4);
    check("lui_early", rf(1), 32'h0);
    cyc(1);
    check("lui_x1", rf(1), 32'h12345000);
    check("pc_after5", dut.if_pc, 32'd20);

    // Branches: BNE taken, BEQ not taken, BLT taken.
    prog = '{addi(1, 0, 1), addi(2, 0, 2),
             enc_b(8, 1, 1, 2), addi(7, 0, 99), addi(3, 0, 1),
             enc_b(8, 0, 1, 2), addi(4, 0, 2),
             enc_b(8, 4, 1, 2), addi(6, 0, 77), addi(5, 0, 3)};
    exp_reg("br_x3", 3, 32'd1);
    exp_reg("br_x4", 4, 32'd2);
    exp_reg("br_x5", 5, 32'd3);
    exp_reg("br_x6_skip", 6, 32'd0);
    exp_reg("br_x7_skip", 7, 32'd0);
    load_prog();
    cyc(30);
    drain_sb();

    // Fibonacci loop.
    exp_reg("fib_x2", 2, 32'd55);
    exp_reg("fib_x1", 1, 32'd0);
    exp_reg("fib_x3", 3, 32'd89);
    load_fib();
    cyc(100);
    drain_sb();

    // Forwarding, store/load, load-use bubble, x0 writes.
    prog = '{addi(5, 0, 7), enc_r(0, 5, 5, 0, 6), enc_r(0, 5, 6, 0, 7),
             addi(1, 0, -300), enc_s(0, 1, 0), enc_i(0, 0, 2, 8, 7'h03),
             enc_r(0, 8, 8, 0, 9), addi(0, 0, 5), enc_r(0, 0, 0, 0, 10),
             enc_s(8, 6, 0), enc_i(11, 0, 2, 11, 7'h03)};
    exp_reg("fw_x6", 6, 32'd14);
    exp_reg("fw_x8", 8, 32'hFFFFFED4);
    exp_reg("fw_x9", 9, 32'hFFFFFDA8);
    exp_reg("x0_x10", 10, 32'd0);
    exp_reg("x0_reg", 0, 32'd0);
    exp_reg("lw_low_bits_x11", 11, 32'd14);
    load_prog();
    cyc(7);
    check("fw_x7_nostall", rf(7), 32'd21);
    cyc(4);
    check("lu_x9_early", rf(9), 32'h0);
    cyc(1);
    check("lu_x9_bubble", rf(9), 32'hFFFFFDA8);
    cyc(20);
    drain_sb();

    // AUIPC, JAL, JALR (low bit cleared), shifts, compares.
    prog = '{enc_u(1, 12, 7'h17), enc_j(12, 13), addi(14, 0, 99), addi(14, 0, 98),
             addi(15, 0, -16), enc_i(32'h402, 15, 5, 16, 7'h13),
             enc_i(28, 15, 5, 17, 7'h13), enc_i(-1, 15, 3, 18, 7'h13),
             enc_r(0, 0, 15, 2, 19), enc_i(33, 13, 0, 20, 7'h67),
             enc_i(5, 20, 4, 21, 7'h13), enc_b(8, 5, 15, 0), addi(22, 0, 1)};
    exp_reg("auipc_x12", 12, 32'h1000);
    exp_reg("jal_x13", 13, 32'd8);
    exp_reg("jal_skip_x14", 14, 32'd0);
    exp_reg("srai_x16", 16, 32'hFFFFFFFC);
    exp_reg("srli_x17", 17, 32'hF);
    exp_reg("sltiu_x18", 18, 32'd1);
    exp_reg("slt_x19", 19, 32'd1);
    exp_reg("jalr_x20", 20, 32'd40);
    exp_reg("xori_x21", 21, 32'd45);
    exp_reg("bge_nt_x22", 22, 32'd1);
    load_prog();
    cyc(40);
    drain_sb();

    // Reset in the middle of the Fibonacci loop, then rerun.
    load_fib();
    cyc(30);
    rst = 1'b1;
    cyc(1);
    check("midrst_pc", dut.if_pc, 32'h0);
    for (int r = 1; r < 32; r++) check($sformatf("midrst_x%0d", r), rf(r), 32'h0);
    rst = 1'b0;
    exp_reg("rerun_x2", 2, 32'd55);
    cyc(100);
    drain_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
